// File: rtl/trojan_pkg.sv
// Shared types and constants for the trojan activation harness.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trojan_pkg;

  localparam int TRIG_W = 32;
  localparam int KEY_W  = 56;
  localparam int CODE_W = 2;
  localparam int BASE_W = TRIG_W - CODE_W;

  localparam logic [CODE_W-1:0] IDLE_CODE = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAP   = 2'd2,
    WATCH = 2'd3
  } trig_gen_state_t;

  function automatic logic [TRIG_W-1:0] idle_word(input logic [BASE_W-1:0] base);
    return {base, IDLE_CODE};
  endfunction

endpackage

// File: rtl/trojan_payload_mon.sv
// Payload watcher: latches a baseline, accumulates a sticky changed flag, captures the last sample.
// Latency: changed/payload_cap update on the edge that samples the watch cycle.
// Backpressure: none; clr and watch are single-cycle strobes from the FSM.
module trojan_payload_mon
  import trojan_pkg::*;
#(
  parameter int WATCH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             watch,
  input  logic [KEY_W-1:0] payload,
  output logic             last,
  output logic             changed,
  output logic [KEY_W-1:0] payload_cap
);

  logic [KEY_W-1:0] baseline;
  logic [7:0]       wcnt;

  assign last = (wcnt == 8'(WATCH_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baseline    <= '0;
      wcnt        <= '0;
      changed     <= 1'b0;
      payload_cap <= '0;
    end else if (clr) begin
      baseline <= payload;
      wcnt     <= '0;
      changed  <= 1'b0;
    end else if (watch) begin
      // full-width compare; any bit flip in the window sets the sticky flag
      changed <= changed | (payload != baseline);
      if (last) begin
        payload_cap <= payload;
        wcnt        <= '0;
      end else begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/trojan_trig_gen.sv
// Replays a 2-bit activation code sequence on trigger, then watches payload; gap insertion under TROJAN_TRIG_GAP_EN.
// Latency: code 0 one cycle after start; done SEQ_LEN + WATCH_CYC (+ (SEQ_LEN-1)*gap) cycles after start.
// Backpressure: start ignored while busy; abort wins over everything and suppresses done.
module trojan_trig_gen
  import trojan_pkg::*;
#(
  parameter int SEQ_LEN   = 3,
  parameter int WATCH_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [BASE_W-1:0]       trig_base,
  input  logic [CODE_W*SEQ_LEN-1:0] seq,
  input  logic [3:0]              gap,
  input  logic [KEY_W-1:0]        payload,
  output logic [TRIG_W-1:0]       trigger,
  output logic                    busy,
  output logic                    done,
  output logic                    changed,
  output logic [KEY_W-1:0]        payload_cap
);

  localparam int IDX_W = $clog2(SEQ_LEN + 1);

  trig_gen_state_t             state;
  logic [IDX_W-1:0]            idx;
  logic [BASE_W-1:0]           base_q;
  logic [CODE_W*SEQ_LEN-1:0]   seq_q;
  logic [CODE_W-1:0]           next_code;
  logic                        mon_clr;
  logic                        mon_watch;
  logic                        mon_last;

`ifdef TROJAN_TRIG_GAP_EN
  logic [3:0] gap_q;
  logic [3:0] gcnt;
`else
  logic unused_gap;
  assign unused_gap = ^gap;
`endif

  always_comb begin
    next_code = IDLE_CODE;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx == IDX_W'(i)) next_code = seq_q[CODE_W*i +: CODE_W];
    end
  end

  assign mon_clr   = (state == IDLE)  && start && !abort;
  assign mon_watch = (state == WATCH) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      base_q  <= '0;
      seq_q   <= '0;
      trigger <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef TROJAN_TRIG_GAP_EN
      gap_q   <= '0;
      gcnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        trigger <= idle_word(base_q);
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base_q  <= trig_base;
              seq_q   <= seq;
`ifdef TROJAN_TRIG_GAP_EN
              gap_q   <= gap;
`endif
              trigger <= {trig_base, seq[CODE_W-1:0]};
              idx     <= IDX_W'(1);
              busy    <= 1'b1;
              state   <= SEND;
            end
          end
          SEND: begin
            if (idx == IDX_W'(SEQ_LEN)) begin
              trigger <= idle_word(base_q);
              state   <= WATCH;
            end
`ifdef TROJAN_TRIG_GAP_EN
            else if (gap_q != 4'd0) begin
              trigger <= idle_word(base_q);
              gcnt    <= gap_q - 4'd1;
              state   <= GAP;
            end
`endif
            else begin
              trigger <= {base_q, next_code};
              idx     <= idx + IDX_W'(1);
            end
          end
`ifdef TROJAN_TRIG_GAP_EN
          GAP: begin
            // the expiring gap cycle itself loads the next code
            if (gcnt == 4'd0) begin
              trigger <= {base_q, next_code};
              idx     <= idx + IDX_W'(1);
              state   <= SEND;
            end else begin
              gcnt <= gcnt - 4'd1;
            end
          end
`endif
          WATCH: begin
            if (mon_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  trojan_payload_mon #(
    .WATCH_CYC (WATCH_CYC)
  ) u_mon (
    .clk         (clk),
    .rst         (rst),
    .clr         (mon_clr),
    .watch       (mon_watch),
    .payload     (payload),
    .last        (mon_last),
    .changed     (changed),
    .payload_cap (payload_cap)
  );

endmodule

// File: tb/tb_trojan_trig_gen.sv
// Directed bench for trojan_trig_gen: default instance (3 codes, 4-cycle watch) and a 1/1 instance.
// Inputs driven and outputs sampled on the falling edge.
module tb_trojan_trig_gen;
  import trojan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance a: SEQ_LEN=3, WATCH_CYC=4
  logic              a_start = 0, a_abort = 0;
  logic [29:0]       a_base = 30'h15555554;
  logic [5:0]        a_seq = {2'd3, 2'd1, 2'd2};
  logic [3:0]        a_gap = 4'd0;
  logic [55:0]       a_payload = '0;
  logic [31:0]       a_trigger;
  logic              a_busy, a_done, a_changed;
  logic [55:0]       a_cap;

  // instance b: SEQ_LEN=1, WATCH_CYC=1
  logic              b_start = 0, b_abort = 0;
  logic [29:0]       b_base = 30'h0A;
  logic [1:0]        b_seq = 2'd1;
  logic [3:0]        b_gap = 4'd0;
  logic [55:0]       b_payload = 56'h5A;
  logic [31:0]       b_trigger;
  logic              b_busy, b_done, b_changed;
  logic [55:0]       b_cap;

  trojan_trig_gen #(.SEQ_LEN(3), .WATCH_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .trig_base(a_base),
    .seq(a_seq), .gap(a_gap), .payload(a_payload), .trigger(a_trigger),
    .busy(a_busy), .done(a_done), .changed(a_changed), .payload_cap(a_cap)
  );

  trojan_trig_gen #(.SEQ_LEN(1), .WATCH_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .trig_base(b_base),
    .seq(b_seq), .gap(b_gap), .payload(b_payload), .trigger(b_trigger),
    .busy(b_busy), .done(b_done), .changed(b_changed), .payload_cap(b_cap)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [31:0] tr [0:15];
  logic        dn [0:15];
  logic        bz [0:15];

  // start on the next edge, then record one observation per cycle (k=0 is just after the start edge)
  task automatic run_a(input int ncyc, input int step_k, input logic [55:0] p1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      tr[k] = a_trigger;
      dn[k] = a_done;
      bz[k] = a_busy;
      if (k == step_k) a_payload = p1;
      @(negedge clk);
    end
  endtask

  function automatic int first_done(input int n);
    for (int k = 0; k < n; k++) if (dn[k]) return k;
    return -1;
  endfunction

  function automatic int done_count(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (dn[k]) c++;
    return c;
  endfunction

  int ndone;

  initial begin
    // reset values
    @(negedge clk);
    check("rst_trigger", a_trigger, 32'h0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_changed", a_changed, 0);
    check("rst_cap", a_cap, 0);
    rst = 1'b1;
    @(negedge clk);

    // base run, payload constant
    a_payload = 56'h123456789ABCDE;
    run_a(10, -1, '0);
    check("base_code0", tr[0], 32'h55555552);
    check("base_code1", tr[1], 32'h55555551);
    check("base_code2", tr[2], 32'h55555553);
    check("base_idle", tr[3], 32'h55555550);
    check("base_idle_hold", tr[6], 32'h55555550);
    check("base_busy_run", bz[6], 1);
    check("base_busy_end", bz[7], 0);
    check("base_done_cyc", first_done(10), 7);
    check("base_done_cnt", done_count(10), 1);
    check("base_changed", a_changed, 0);
    check("base_cap", a_cap, 56'h123456789ABCDE);

    // payload steps two cycles after the last code
    a_payload = '0;
    run_a(10, 4, 56'hFFFFFFFFFFFFFF);
    check("step_done_cyc", first_done(10), 7);
    check("step_changed", a_changed, 1);
    check("step_cap", a_cap, 56'hFFFFFFFFFFFFFF);

    // abort on the second SEND cycle; a start while busy is ignored
    a_start = 1'b1;
    @(negedge clk);
    check("abort_clr_changed", a_changed, 0);
    @(negedge clk);
    a_start = 1'b0;
    check("busy_start_ignored", a_trigger, 32'h55555551);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_trigger", a_trigger, 32'h55555550);
    check("abort_busy", a_busy, 0);
    check("abort_cap_kept", a_cap, 56'hFFFFFFFFFFFFFF);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_busy", a_busy, 0);

    // start and abort on the same idle edge
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    check("same_edge_busy", a_busy, 0);
    check("same_edge_trigger", a_trigger, 32'h55555550);
    ndone = 0;
    for (int k = 0; k < 9; k++) begin
      if (a_done) ndone++;
      @(negedge clk);
    end
    check("same_edge_no_done", ndone, 0);

    // reset mid-SEND
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_trigger", a_trigger, 32'h0);
    check("midrst_busy", a_busy, 0);
    check("midrst_done", a_done, 0);
    check("midrst_changed", a_changed, 0);
    check("midrst_cap", a_cap, 0);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_idle_busy", a_busy, 0);

`ifdef TROJAN_TRIG_GAP_EN
    a_gap = 4'd2;
    run_a(13, -1, '0);
    check("gap_code0", tr[0], 32'h55555552);
    check("gap_idle_a", tr[1], 32'h55555550);
    check("gap_idle_b", tr[2], 32'h55555550);
    check("gap_code1", tr[3], 32'h55555551);
    check("gap_idle_c", tr[5], 32'h55555550);
    check("gap_code2", tr[6], 32'h55555553);
    check("gap_done_cyc", first_done(13), 11);
`else
    // gap input has no effect without the gap feature
    a_gap = 4'd3;
    run_a(10, -1, '0);
    check("nogap_code1", tr[1], 32'h55555551);
    check("nogap_code2", tr[2], 32'h55555553);
    check("nogap_done_cyc", first_done(10), 7);
`endif
    a_gap = 4'd0;

    // single-code, single-cycle watch; restart on each done cycle
    b_start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("b_done_k%0d", k), b_done, (k == 2 || k == 5 || k == 8));
      if (k == 0) check("b_code0", b_trigger, 32'h29);
      if (k == 1) check("b_idle", b_trigger, 32'h28);
      if (k == 2) check("b_busy_done", b_busy, 0);
      if (k == 3) check("b_restart_code", b_trigger, 32'h29);
      if (k == 3) check("b_restart_busy", b_busy, 1);
      b_start = (k == 2 || k == 5);
      @(negedge clk);
    end
    check("b_changed", b_changed, 0);
    check("b_cap", b_cap, 56'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
